// File: rtl/lpif_link_online_ctrl.sv
// Link bring-up sequencer for the LPIF x16 asym2 half-rate master datapath.
// Raises tx_online then rx_online once the PHY is stably ready, and retrains on PHY loss.
module lpif_link_online_ctrl #(
    parameter int CNT_W   = 16,
    parameter int RETRY_W = 8
) (
    input  logic               clk_wr,
    input  logic               rst_wr_n,
    input  logic               link_en,
    input  logic               phy_tx_ready,
    input  logic               phy_rx_ready,
    input  logic [CNT_W-1:0]   settle_value,
    input  logic [CNT_W-1:0]   timeout_value,
    output logic               tx_online,
    output logic               rx_online,
    output logic               link_up,
    output logic               link_err,
    output logic [2:0]         state_dbg,
    output logic [RETRY_W-1:0] retry_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_PHY = 3'd1,
        TX_ON    = 3'd2,
        RX_ON    = 3'd3,
        UP       = 3'd4,
        DOWN     = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    logic             rdy;
    logic             keep;
    logic             tmo_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] tmo_inc;

    assign rdy     = phy_tx_ready & phy_rx_ready;
    assign keep    = rdy & link_en;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign tmo_inc = (tmo_q == CNT_MAX) ? tmo_q : tmo_q + 1'b1;
    assign tmo_hit = (timeout_value != '0) && (tmo_q == timeout_value - 1'b1);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        case (state_q)
            IDLE: begin
                if (link_en) state_d = WAIT_PHY;
            end
            WAIT_PHY: begin
                cnt_d = rdy ? cnt_inc : '0;
                tmo_d = tmo_inc;
                if (!link_en)                        state_d = IDLE;
                else if (rdy && cnt_q >= settle_value) state_d = TX_ON;
                else if (tmo_hit)                    state_d = ERR;
            end
            TX_ON: begin
                cnt_d = cnt_inc;
                if (!keep)                     state_d = DOWN;
                else if (cnt_q >= settle_value) state_d = RX_ON;
            end
            RX_ON: begin
                state_d = keep ? UP : DOWN;
            end
            UP: begin
                if (!keep) state_d = DOWN;
            end
            DOWN: begin
                cnt_d = cnt_inc;
                if (cnt_q >= settle_value) begin
                    if (link_en) begin
                        state_d = WAIT_PHY;
                        if (retry_q != RETRY_MAX) retry_d = retry_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ERR: begin
                if (!link_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Every phase measures its own interval from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
            tmo_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            tx_online <= 1'b0;
            rx_online <= 1'b0;
            link_up   <= 1'b0;
            link_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            // Decoded from the next state so the flags line up with state_q.
            tx_online <= (state_d == TX_ON) || (state_d == RX_ON) || (state_d == UP);
            rx_online <= (state_d == RX_ON) || (state_d == UP);
            link_up   <= (state_d == UP);
            link_err  <= (state_d == ERR);
        end
    end

    assign state_dbg = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_lpif_link_online_ctrl.sv
// Self-checking bench for lpif_link_online_ctrl: vector table, directed corner
// sequences and a randomized run against a phase/streak reference model.
module tb_lpif_link_online_ctrl;

    logic        clk_wr        = 1'b0;
    logic        rst_wr_n      = 1'b0;
    logic        link_en       = 1'b0;
    logic        phy_tx_ready  = 1'b0;
    logic        phy_rx_ready  = 1'b0;
    logic [15:0] settle_value  = '0;
    logic [15:0] timeout_value = '0;
    logic        tx_online;
    logic        rx_online;
    logic        link_up;
    logic        link_err;
    logic [2:0]  state_dbg;
    logic [7:0]  retry_cnt;

    lpif_link_online_ctrl #(.CNT_W(16), .RETRY_W(8)) dut (
        .clk_wr        (clk_wr),
        .rst_wr_n      (rst_wr_n),
        .link_en       (link_en),
        .phy_tx_ready  (phy_tx_ready),
        .phy_rx_ready  (phy_rx_ready),
        .settle_value  (settle_value),
        .timeout_value (timeout_value),
        .tx_online     (tx_online),
        .rx_online     (rx_online),
        .link_up       (link_up),
        .link_err      (link_err),
        .state_dbg     (state_dbg),
        .retry_cnt     (retry_cnt)
    );

    always #5 clk_wr = ~clk_wr;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: phase number, cycles spent in the phase, and current run
    // of consecutive ready cycles; thresholds are compared arithmetically.
    int m_phase  = 0;
    int m_age    = 0;
    int m_streak = 0;
    int m_retry  = 0;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_age    = 0;
        m_streak = 0;
        m_retry  = 0;
    endtask

    task automatic model_step(input bit le, input bit rdy, input int settle, input int tmo_v);
        int  nxt;
        bit  go;
        nxt = m_phase;
        go  = le && rdy;
        case (m_phase)
            0: if (le) nxt = 1;
            1: begin
                if (!le) nxt = 0;
                else if (rdy && sat16(m_streak) >= settle) nxt = 2;
                else if (tmo_v != 0 && sat16(m_age) == tmo_v - 1) nxt = 6;
            end
            2: begin
                if (!go) nxt = 5;
                else if (sat16(m_age) >= settle) nxt = 3;
            end
            3: nxt = go ? 4 : 5;
            4: if (!go) nxt = 5;
            5: if (sat16(m_age) >= settle) begin
                nxt = le ? 1 : 0;
                if (le && m_retry < 255) m_retry++;
            end
            6: if (!le) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != m_phase) begin
            m_age    = 0;
            m_streak = 0;
        end else begin
            m_age++;
            m_streak = rdy ? m_streak + 1 : 0;
        end
        m_phase = nxt;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".state"}, int'(state_dbg), m_phase);
        check({tag, ".tx_online"}, int'(tx_online), int'(m_phase == 2 || m_phase == 3 || m_phase == 4));
        check({tag, ".rx_online"}, int'(rx_online), int'(m_phase == 3 || m_phase == 4));
        check({tag, ".link_up"}, int'(link_up), int'(m_phase == 4));
        check({tag, ".link_err"}, int'(link_err), int'(m_phase == 6));
        check({tag, ".retry_cnt"}, int'(retry_cnt), m_retry);
    endtask

    task automatic tick(input string tag = "model");
        @(posedge clk_wr);
        model_step(link_en, phy_tx_ready && phy_rx_ready, int'(settle_value), int'(timeout_value));
        #1;
        compare_model(tag);
    endtask

    // Asserted away from the clock edge; outputs must clear without a clock.
    task automatic apply_reset();
        rst_wr_n = 1'b0;
        #1;
        model_reset();
        check("rst.state", int'(state_dbg), 0);
        check("rst.tx_online", int'(tx_online), 0);
        check("rst.rx_online", int'(rx_online), 0);
        check("rst.link_up", int'(link_up), 0);
        check("rst.link_err", int'(link_err), 0);
        check("rst.retry_cnt", int'(retry_cnt), 0);
        link_en      = 1'b0;
        phy_tx_ready = 1'b0;
        phy_rx_ready = 1'b0;
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
    endtask

    task automatic wait_state(input int target, input int budget, output int n);
        n = 0;
        while (int'(state_dbg) != target && n <= budget) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic       le;
        logic       tr;
        logic       rr;
        logic [2:0] st;
        logic       tx;
        logic       rx;
        logic       up;
        logic       err;
        logic [7:0] retry;
    } vec_t;

    vec_t vt[17];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Basic bring-up, PHY loss retrain and disable paths with settle=0, timeout=0.
        vt[0]  = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[10] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[11] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[13] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[14] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[15] = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[16] = '{1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

        #3;
        apply_reset();
        settle_value  = 16'd0;
        timeout_value = 16'd0;
        for (int i = 0; i < 17; i++) begin
            link_en      = vt[i].le;
            phy_tx_ready = vt[i].tr;
            phy_rx_ready = vt[i].rr;
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.state", i), int'(state_dbg), int'(vt[i].st));
            check($sformatf("vec%0d.tx_online", i), int'(tx_online), int'(vt[i].tx));
            check($sformatf("vec%0d.rx_online", i), int'(rx_online), int'(vt[i].rx));
            check($sformatf("vec%0d.link_up", i), int'(link_up), int'(vt[i].up));
            check($sformatf("vec%0d.link_err", i), int'(link_err), int'(vt[i].err));
            check($sformatf("vec%0d.retry_cnt", i), int'(retry_cnt), int'(vt[i].retry));
        end

        // Settle interval with a one-cycle ready glitch in WAIT_PHY.
        apply_reset();
        settle_value  = 16'd5;
        timeout_value = 16'd0;
        link_en       = 1'b1;
        tick();
        phy_tx_ready = 1'b1;
        phy_rx_ready = 1'b1;
        repeat (3) tick();
        phy_rx_ready = 1'b0;
        tick();
        phy_rx_ready = 1'b1;
        wait_state(2, 20, n);
        check("glitch.wait_to_tx_on_cycles", n, 6);
        wait_state(3, 20, n);
        check("settle.tx_on_cycles", n, 6);
        wait_state(4, 20, n);
        check("settle.rx_on_to_up_cycles", n, 1);

        // PHY loss in UP: both online flags fall together, DOWN lasts settle+1.
        phy_rx_ready = 1'b0;
        tick();
        phy_rx_ready = 1'b1;
        check("loss.state", int'(state_dbg), 5);
        check("loss.tx_online", int'(tx_online), 0);
        check("loss.rx_online", int'(rx_online), 0);
        wait_state(1, 20, n);
        check("loss.down_cycles", n, 6);
        check("loss.retry_cnt", int'(retry_cnt), 1);
        wait_state(2, 20, n);
        check("loss.rewait_cycles", n, 6);

        // Asynchronous reset in the middle of TX_ON.
        tick();
        check("mid_tx.tx_online_before", int'(tx_online), 1);
        #2;
        apply_reset();

        // WAIT_PHY timeout into ERR, held until link_en drops.
        settle_value  = 16'd0;
        timeout_value = 16'd10;
        link_en       = 1'b1;
        tick();
        wait_state(6, 40, n);
        check("tmo.wait_cycles", n, 10);
        check("tmo.link_err", int'(link_err), 1);
        repeat (5) tick();
        check("tmo.hold_state", int'(state_dbg), 6);
        link_en = 1'b0;
        tick();
        check("tmo.exit_state", int'(state_dbg), 0);
        check("tmo.exit_link_err", int'(link_err), 0);
        check("tmo.retry_cnt", int'(retry_cnt), 0);

        // Retry counter saturation across 260 retrains.
        apply_reset();
        settle_value  = 16'd0;
        timeout_value = 16'd0;
        link_en       = 1'b1;
        phy_tx_ready  = 1'b1;
        phy_rx_ready  = 1'b1;
        for (int i = 0; i < 260; i++) begin
            wait_state(4, 20, n);
            if (n > 20) begin
                check("sat.reach_up", n, -1);
                break;
            end
            phy_tx_ready = 1'b0;
            tick();
            phy_tx_ready = 1'b1;
        end
        wait_state(4, 20, n);
        check("sat.retry_cnt_255", int'(retry_cnt), 255);
        phy_tx_ready = 1'b0;
        tick();
        phy_tx_ready = 1'b1;
        wait_state(4, 20, n);
        check("sat.retry_cnt_held", int'(retry_cnt), 255);

        // Randomized run against the reference model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_phase == 0 && $urandom_range(0, 3) == 0) begin
                settle_value  = 16'($urandom_range(0, 4));
                timeout_value = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 15));
            end
            link_en      = ($urandom_range(0, 19) != 0);
            phy_tx_ready = ($urandom_range(0, 9) != 0);
            phy_rx_ready = ($urandom_range(0, 9) != 0);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
